// File: rtl/fifo_ms_arb.sv
// Multi-stream tagged FIFO: one tagged write port feeds FLUX circular queues,
// per-stream read requests are arbitrated onto a single registered output.
module fifo_ms_arb #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FLUX      = 2,
    parameter int MODE      = 0,
    parameter int AF_LEVEL  = DEPTH - 1,
    localparam int TAG_WIDTH = $clog2(FLUX),
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      wr,
    input  logic [WIDTH-1:0]          datain,
    input  logic [FLUX-1:0]           rd,
    output logic [FLUX-1:0]           full,
    output logic [FLUX-1:0]           empty,
    output logic [FLUX-1:0]           almost_full,
    output logic [FLUX*CNT_WIDTH-1:0] count,
    output logic [WIDTH-1:0]          dataout,
    output logic                      dout_valid,
    output logic [TAG_WIDTH-1:0]      dout_tag,
    output logic                      wr_drop
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_LEVEL);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
    localparam logic [TAG_WIDTH-1:0] TAG_LAST = TAG_WIDTH'(FLUX - 1);

    logic [WIDTH-1:0]     mem [FLUX][DEPTH];
    logic [PTR_WIDTH-1:0] wp  [FLUX];
    logic [PTR_WIDTH-1:0] rp  [FLUX];
    logic [CNT_WIDTH-1:0] cnt [FLUX];
    logic [TAG_WIDTH-1:0] last;

    logic [TAG_WIDTH-1:0] tag;
    logic [FLUX-1:0]      wr_acc;
    logic [FLUX-1:0]      elig;
    logic [FLUX-1:0]      gnt;
    logic [TAG_WIDTH-1:0] g;
    logic                 any;
    logic [WIDTH-1:0]     pop_data;

    assign tag  = datain[WIDTH-1 -: TAG_WIDTH];
    assign elig = rd & ~empty;

    for (genvar i = 0; i < FLUX; i++) begin : g_flag
        assign full[i]        = (cnt[i] == CNT_FULL);
        assign empty[i]       = (cnt[i] == '0);
        assign almost_full[i] = (cnt[i] >= CNT_AF);
        assign count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
        // A tag outside 0..FLUX-1 matches no stream and is therefore dropped.
        assign wr_acc[i] = wr && (int'(tag) == i) && !full[i];
    end

    always_comb begin
        int idx;
        idx      = 0;
        g        = '0;
        any      = 1'b0;
        gnt      = '0;
        pop_data = '0;
        if (MODE == 0) begin
            for (int i = 0; i < FLUX; i++) begin
                if (elig[i]) begin
                    g   = TAG_WIDTH'(i);
                    any = 1'b1;
                end
            end
        end else begin
            // Rotating search starting just after the last granted stream.
            for (int k = 1; k <= FLUX; k++) begin
                idx = int'(last) + k;
                if (idx >= FLUX) idx = idx - FLUX;
                for (int i = 0; i < FLUX; i++) begin
                    if (!any && idx == i && elig[i]) begin
                        g   = TAG_WIDTH'(i);
                        any = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < FLUX; i++) begin
            if (any && int'(g) == i) begin
                gnt[i]   = 1'b1;
                pop_data = mem[i][rp[i]];
            end
        end
    end

    always_ff @(posedge ck) begin
        for (int i = 0; i < FLUX; i++) begin
            if (!rst && wr_acc[i]) mem[i][wp[i]] <= datain;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            last       <= TAG_LAST;
            dataout    <= '0;
            dout_tag   <= '0;
            dout_valid <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                if (wr_acc[i]) wp[i] <= (wp[i] == PTR_LAST) ? '0 : wp[i] + 1'b1;
                if (gnt[i])    rp[i] <= (rp[i] == PTR_LAST) ? '0 : rp[i] + 1'b1;
                case ({wr_acc[i], gnt[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
            wr_drop    <= wr && (wr_acc == '0);
            dout_valid <= any;
            if (any) begin
                dataout  <= pop_data;
                dout_tag <= g;
                last     <= g;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ms_arb.sv
// Directed bench for fifo_ms_arb: three instances cover DEPTH=3 fixed priority,
// DEPTH=4 round-robin, and FLUX=3 out-of-range tags plus mid-burst reset.
module tb_fifo_ms_arb;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    // Instance A: FLUX=2 DEPTH=3 MODE=0
    logic       a_rst = 1'b1, a_wr = 1'b0;
    logic [7:0] a_datain = '0;
    logic [1:0] a_rd = '0, a_full, a_empty, a_af;
    logic [3:0] a_count;
    logic [7:0] a_dataout;
    logic       a_valid, a_tag, a_wr_drop;

    fifo_ms_arb #(.WIDTH(8), .DEPTH(3), .FLUX(2), .MODE(0)) u_a (
        .ck(ck), .rst(a_rst), .wr(a_wr), .datain(a_datain), .rd(a_rd),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .count(a_count),
        .dataout(a_dataout), .dout_valid(a_valid), .dout_tag(a_tag), .wr_drop(a_wr_drop)
    );

    // Instance B: FLUX=2 DEPTH=4 MODE=1
    logic       b_rst = 1'b1, b_wr = 1'b0;
    logic [7:0] b_datain = '0;
    logic [1:0] b_rd = '0, b_full, b_empty, b_af;
    logic [5:0] b_count;
    logic [7:0] b_dataout;
    logic       b_valid, b_tag, b_wr_drop;

    fifo_ms_arb #(.WIDTH(8), .DEPTH(4), .FLUX(2), .MODE(1)) u_b (
        .ck(ck), .rst(b_rst), .wr(b_wr), .datain(b_datain), .rd(b_rd),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .count(b_count),
        .dataout(b_dataout), .dout_valid(b_valid), .dout_tag(b_tag), .wr_drop(b_wr_drop)
    );

    // Instance C: FLUX=3 DEPTH=4 MODE=0, tag = datain[7:6]
    logic       c_rst = 1'b1, c_wr = 1'b0;
    logic [7:0] c_datain = '0;
    logic [2:0] c_rd = '0, c_full, c_empty, c_af;
    logic [8:0] c_count;
    logic [7:0] c_dataout;
    logic       c_valid, c_wr_drop;
    logic [1:0] c_tag;

    fifo_ms_arb #(.WIDTH(8), .DEPTH(4), .FLUX(3), .MODE(0)) u_c (
        .ck(ck), .rst(c_rst), .wr(c_wr), .datain(c_datain), .rd(c_rd),
        .full(c_full), .empty(c_empty), .almost_full(c_af), .count(c_count),
        .dataout(c_dataout), .dout_valid(c_valid), .dout_tag(c_tag), .wr_drop(c_wr_drop)
    );

    logic [7:0] exp_d [4];
    logic       exp_t [4];

    initial begin
        tick;
        tick;
        a_rst = 1'b0;
        b_rst = 1'b0;
        c_rst = 1'b0;

        // ---------------- A: reset state and idle reads
        chk("a_rst_empty", a_empty, 2'b11);
        chk("a_rst_full", a_full, 2'b00);
        chk("a_rst_af", a_af, 2'b00);
        chk("a_rst_count", a_count, 4'h0);
        chk("a_rst_valid", a_valid, 1'b0);
        chk("a_rst_dataout", a_dataout, 8'h00);
        chk("a_rst_wr_drop", a_wr_drop, 1'b0);
        a_rd = 2'b11;
        repeat (3) begin
            tick;
            chk("a_idle_valid", a_valid, 1'b0);
        end
        a_rd = 2'b00;

        // ---------------- A: fill stream 1 past full
        a_wr = 1'b1;
        exp_d = '{8'h81, 8'h82, 8'h83, 8'h00};
        for (int i = 0; i < 3; i++) begin
            a_datain = exp_d[i];
            tick;
        end
        chk("a_fill_full", a_full, 2'b10);
        chk("a_fill_af", a_af, 2'b10);
        chk("a_fill_count", a_count, 4'b1100);
        chk("a_fill_drop", a_wr_drop, 1'b0);
        a_datain = 8'h84;
        tick;
        chk("a_ovf_drop", a_wr_drop, 1'b1);
        chk("a_ovf_count", a_count, 4'b1100);
        a_wr = 1'b0;
        tick;
        chk("a_drop_pulse", a_wr_drop, 1'b0);

        a_rd = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("a_rd_data", a_dataout, exp_d[i]);
            chk("a_rd_tag", a_tag, 1'b1);
            chk("a_rd_valid", a_valid, 1'b1);
        end
        chk("a_drain_empty", a_empty, 2'b11);
        chk("a_drain_count", a_count, 4'h0);
        a_rd = 2'b00;
        tick;
        chk("a_hold_valid", a_valid, 1'b0);
        chk("a_hold_data", a_dataout, 8'h83);
        chk("a_hold_tag", a_tag, 1'b1);

        // pointers wrapped: next word lands in slot 0 and reads back
        a_wr = 1'b1;
        a_datain = 8'h85;
        tick;
        a_wr = 1'b0;
        a_rd = 2'b10;
        tick;
        chk("a_wrap_data", a_dataout, 8'h85);
        chk("a_wrap_valid", a_valid, 1'b1);
        a_rd = 2'b00;

        // ---------------- A: fixed priority, stream 1 drains first
        a_wr = 1'b1;
        exp_d = '{8'h01, 8'h02, 8'h91, 8'h92};
        for (int i = 0; i < 4; i++) begin
            a_datain = exp_d[i];
            tick;
        end
        a_wr = 1'b0;
        a_rd = 2'b11;
        exp_d = '{8'h91, 8'h92, 8'h01, 8'h02};
        exp_t = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("a_prio_data", a_dataout, exp_d[i]);
            chk("a_prio_tag", a_tag, exp_t[i]);
        end
        chk("a_prio_empty", a_empty, 2'b11);
        a_rd = 2'b00;

        // ---------------- B: round-robin alternates starting at stream 0
        chk("b_rst_empty", b_empty, 2'b11);
        b_wr = 1'b1;
        exp_d = '{8'h01, 8'h02, 8'h91, 8'h92};
        for (int i = 0; i < 4; i++) begin
            b_datain = exp_d[i];
            tick;
        end
        b_wr = 1'b0;
        b_rd = 2'b11;
        exp_d = '{8'h01, 8'h91, 8'h02, 8'h92};
        exp_t = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("b_rr_data", b_dataout, exp_d[i]);
            chk("b_rr_tag", b_tag, exp_t[i]);
        end
        b_rd = 2'b00;

        // ---------------- B: write to full stream with concurrent pop
        b_wr = 1'b1;
        exp_d = '{8'h11, 8'h12, 8'h13, 8'h14};
        for (int i = 0; i < 4; i++) begin
            b_datain = exp_d[i];
            tick;
        end
        chk("b_full0", b_full, 2'b01);
        chk("b_full_count", b_count, 6'b000_100);
        b_datain = 8'h15;
        b_rd = 2'b01;
        tick;
        chk("b_fullpop_drop", b_wr_drop, 1'b1);
        chk("b_fullpop_data", b_dataout, 8'h11);
        chk("b_fullpop_valid", b_valid, 1'b1);
        chk("b_fullpop_count", b_count, 6'b000_011);
        b_wr = 1'b0;
        tick;
        chk("b_pop_data", b_dataout, 8'h12);
        chk("b_pop_count", b_count, 6'b000_010);

        // simultaneous write and pop with two words held
        b_wr = 1'b1;
        b_datain = 8'h16;
        tick;
        chk("b_wrpop_data", b_dataout, 8'h13);
        chk("b_wrpop_count", b_count, 6'b000_010);
        chk("b_wrpop_drop", b_wr_drop, 1'b0);
        b_wr = 1'b0;
        tick;
        chk("b_tail_data0", b_dataout, 8'h14);
        tick;
        chk("b_tail_data1", b_dataout, 8'h16);
        chk("b_tail_count", b_count, 6'b000_000);
        b_rd = 2'b00;

        // ---------------- C: out-of-range tag and mid-burst reset
        chk("c_rst_empty", c_empty, 3'b111);
        c_wr = 1'b1;
        c_datain = 8'h41;
        tick;
        chk("c_wr_count", c_count, 9'h008);
        c_datain = 8'hC5;
        tick;
        chk("c_badtag_drop", c_wr_drop, 1'b1);
        chk("c_badtag_count", c_count, 9'h008);
        c_datain = 8'h01;
        tick;
        chk("c_ok_drop", c_wr_drop, 1'b0);
        chk("c_ok_count", c_count, 9'h009);
        c_datain = 8'h82;
        c_rd = 3'b010;
        tick;
        chk("c_pop_data", c_dataout, 8'h41);
        chk("c_pop_tag", c_tag, 2'd1);
        chk("c_pop_valid", c_valid, 1'b1);
        chk("c_pop_count", c_count, 9'h041);
        c_rst = 1'b1;
        c_datain = 8'h83;
        c_rd = 3'b011;
        tick;
        chk("c_mrst_count", c_count, 9'h000);
        chk("c_mrst_empty", c_empty, 3'b111);
        chk("c_mrst_full", c_full, 3'b000);
        chk("c_mrst_af", c_af, 3'b000);
        chk("c_mrst_valid", c_valid, 1'b0);
        chk("c_mrst_data", c_dataout, 8'h00);
        chk("c_mrst_tag", c_tag, 2'd0);
        chk("c_mrst_drop", c_wr_drop, 1'b0);
        c_rst = 1'b0;
        c_wr = 1'b0;
        c_rd = 3'b000;
        tick;
        chk("c_post_empty", c_empty, 3'b111);
        chk("c_post_count", c_count, 9'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
